cv32e40x_xif_result_tx: RTL and testbench
=========================================

// Module: cv32e40x_xif_result_tx
// PURPOSE
//  Coprocessor-side transmitter of the eXtension-interface result channel; it is the opposite end from the core's WB-stage result consumer.
//  - Buffers results from the coprocessor execution units in issue order.
//  - Tracks the commit/kill status that the core sends per instruction id.
//  - Drives result_valid/result to the core only for committed instructions. Killed results are discarded silently.
// PARAMETERS
//  DEPTH        4   result queue entries (power of 2, >=2)
//  X_ID_WIDTH   4   instruction id width; commit table has 2**X_ID_WIDTH slots
//  X_RFW_WIDTH  32  result data width
// PORTS
//  clk              in   1            clock
//  rst              in   1            synchronous reset, active-high
//  exe_valid_i      in   1            execution unit offers a result
//  exe_ready_o      out  1            queue accepts result (= !full)
//  exe_id_i         in   X_ID_WIDTH   id of offered result
//  exe_data_i       in   X_RFW_WIDTH  result data
//  exe_rd_i         in   5            destination register
//  exe_we_i         in   1            register write enable
//  exe_exc_i        in   1            synchronous exception
//  exe_exccode_i    in   6            exception code
//  commit_valid_i   in   1            core commit/kill strobe
//  commit_id_i      in   X_ID_WIDTH   id being committed/killed
//  commit_kill_i    in   1            1 = kill, 0 = commit
//  result_valid_o   out  1            result offered to core
//  result_ready_i   in   1            core accepts result
//  result_id_o/data_o/rd_o/we_o/exc_o/exccode_o  out  as exe_*  head result fields
//  empty_o          out  1            queue empty and no bypass in flight
// BEHAVIOUR
//  - Reset: queue empty; wr/rd ptrs = 0; all commit-table slots = NONE.
//    Outputs after reset: exe_ready_o = 1, result_valid_o = 0, result fields = 0, empty_o = 1.
//  - Queue
//    - Push when exe_valid_i && exe_ready_o. Pop when head is consumed or discarded.
//    - Ptrs wrap modulo DEPTH; count has width $clog2(DEPTH)+1.
//    - Push and pop in the same cycle leave the count unchanged. When full, exe_ready_o = 0 (no pop-bypass into ready).
//  - Commit table: per id, a 2-bit state, NONE -> COMMIT or NONE -> KILL, written on commit_valid_i.
//    - The write is visible the next cycle; commit may arrive before or after the result is pushed.
//    - The slot returns to NONE in the cycle its head entry pops or is discarded.
//    - If a commit targets a slot that is not NONE, the write is ignored (assertion flags it).
//  - Head handling, each cycle with queue non-empty:
//    - table[head.id] = COMMIT: result_valid_o = 1 and fields = head. Pop on result_ready_i.
//    - table[head.id] = KILL: result_valid_o = 0. Discard the head in this cycle (1 per cycle).
//    - table[head.id] = NONE: result_valid_o = 0. Wait.
//  - Handshake rules
//    - Once result_valid_o = 1 it stays high, with all fields stable, until result_ready_i.
//    - A kill for an id whose result is already offered is a protocol violation (assertion); the result is still delivered.
//    - result_ready_i while result_valid_o = 0 has no effect.
//  - Latency: push -> result_valid_o is 1 cycle minimum (entry registered), provided commit was seen at least 1 cycle earlier.
//  - Throughput: 1 result per cycle sustained.
//  - Mid-operation reset: everything is flushed in the cycle rst is high. No result is offered in the following cycle.
// CONFIGURATION
//  CV32E40X_XIF_RESULT_BYPASS_EN
//  - Defined: when the queue is empty, table[exe_id_i] = COMMIT and result_ready_i = 1, the offered exe result goes to the core combinationally in the same cycle and is never written to the queue (0-cycle latency).
//    - If result_ready_i = 0, the result is pushed instead, so the valid/stability rule still holds.
//  - Undefined: no exe_* -> result_* combinational path; minimum latency is 1 cycle.
// STRUCTURE
//  - cv32e40x_pkg gains:
//    - xif_result_entry_t: id, data, rd, we, exc, exccode.
//    - xif_commit_state_e: COMMIT_NONE = 2'b00, COMMIT_OK = 2'b01, COMMIT_KILL = 2'b10.
//  - One sub-module, cv32e40x_xif_commit_table: the id-indexed state array, with a write port on commit, a clear port on pop, and two read ports (head id, exe id).
//  - The queue storage, pointers and head control stay in this module.
// TESTING
//  1. Commit id 3 at cycle 0, push id 3 data 0xDEADBEEF at cycle 1 -> result_valid_o = 1 at cycle 2 with data 0xDEADBEEF; ready at cycle 2 pops it; empty_o = 1 at cycle 3.
//  2. Push ids 1,2 without commits, hold result_ready_i = 1 -> no result_valid_o. Commit 2 then 1 -> id 1 is delivered first, then id 2 (issue order).
//  3. Push ids 4,5; kill 4, commit 5 -> id 4 is discarded with result_valid_o never high; id 5 is delivered one cycle later; table slots 4 and 5 return to NONE.
//  4. Fill DEPTH = 4 entries (ids 0-3 committed) with result_ready_i = 0 -> exe_ready_o = 0 and the fields are stable for 10 cycles. Raise ready -> 4 results on 4 consecutive cycles, and exe_ready_o = 1 after the first pop.
//  5. Simultaneous push id 6 and pop id 5 with count = 2 -> count stays 2 and order is preserved. Assert rst mid-stream -> next cycle result_valid_o = 0, exe_ready_o = 1, empty_o = 1.
//  6. With the BYPASS macro: empty queue, id 7 committed, exe_valid_i and result_ready_i both high -> result_valid_o = 1 in the same cycle with exe_data_i and the queue stays empty. Without the macro, valid follows 1 cycle later.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared eXtension-interface result types: queue entry payload and per-id commit state.
package cv32e40x_pkg;

  localparam int unsigned XIF_ID_WIDTH  = 4;
  localparam int unsigned XIF_RFW_WIDTH = 32;

  // One buffered coprocessor result, in the order the fields appear on the result channel.
  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]  id;
    logic [XIF_RFW_WIDTH-1:0] data;
    logic [4:0]               rd;
    logic                     we;
    logic                     exc;
    logic [5:0]               exccode;
  } xif_result_entry_t;

  // Commit status the core has reported for an instruction id.
  typedef enum logic [1:0] {
    COMMIT_NONE = 2'b00,
    COMMIT_OK   = 2'b01,
    COMMIT_KILL = 2'b10
  } xif_commit_state_e;

endpackage

// File: rtl/cv32e40x_xif_commit_table.sv
// Id-indexed commit/kill state array: one write port (core commit strobe),
// one clear port (result leaving the transmitter), two combinational read ports.
module cv32e40x_xif_commit_table
  import cv32e40x_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [X_ID_WIDTH-1:0] wr_id,
  input  logic                  wr_kill,
  input  logic                  clr_valid,
  input  logic [X_ID_WIDTH-1:0] clr_id,
  input  logic [X_ID_WIDTH-1:0] head_id,
  output xif_commit_state_e     head_state_c,
  input  logic [X_ID_WIDTH-1:0] exe_id,
  output xif_commit_state_e     exe_state_c
);

  localparam int unsigned NUM_SLOTS = 2 ** X_ID_WIDTH;

  xif_commit_state_e slots [NUM_SLOTS];
  logic              wr_accept;

  // A slot only moves out of NONE once; a second write before it is cleared is dropped.
  assign wr_accept    = wr_valid && (slots[wr_id] == COMMIT_NONE);
  assign head_state_c = slots[head_id];
  assign exe_state_c  = slots[exe_id];

  // Slot update: clear on result departure, set on accepted commit/kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '{default: COMMIT_NONE};
    end else begin
      if (clr_valid) slots[clr_id] <= COMMIT_NONE;
      if (wr_accept) slots[wr_id]  <= wr_kill ? COMMIT_KILL : COMMIT_OK;
    end
  end

  // The core must not commit or kill an id that is still outstanding.
  a_commit_to_free_slot: assert property (@(posedge clk) disable iff (rst)
    wr_valid |-> (slots[wr_id] == COMMIT_NONE));

endmodule

// File: rtl/cv32e40x_xif_result_tx.sv
// Coprocessor-side eXtension-interface result transmitter.
// Buffers execution results in issue order and forwards them to the core only once
// the core has committed the id; killed results are dropped without a handshake.
// Optional macro CV32E40X_XIF_RESULT_BYPASS_EN: zero-latency exe->result path when the
// queue is empty, the id is already committed and the core is ready.
module cv32e40x_xif_result_tx
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_ID_WIDTH  = XIF_ID_WIDTH,
  parameter int unsigned X_RFW_WIDTH = XIF_RFW_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exe_valid_i,
  output logic                   exe_ready_o,
  input  logic [X_ID_WIDTH-1:0]  exe_id_i,
  input  logic [X_RFW_WIDTH-1:0] exe_data_i,
  input  logic [4:0]             exe_rd_i,
  input  logic                   exe_we_i,
  input  logic                   exe_exc_i,
  input  logic [5:0]             exe_exccode_i,
  input  logic                   commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  input  logic                   commit_kill_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [X_ID_WIDTH-1:0]  result_id_o,
  output logic [X_RFW_WIDTH-1:0] result_data_o,
  output logic [4:0]             result_rd_o,
  output logic                   result_we_o,
  output logic                   result_exc_o,
  output logic [5:0]             result_exccode_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  xif_result_entry_t      queue_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [CNT_WIDTH-1:0]   count;

  xif_result_entry_t      head;
  xif_result_entry_t      exe_entry;
  xif_result_entry_t      out_entry;
  xif_commit_state_e      head_state;
  xif_commit_state_e      exe_state;

  logic queue_empty;
  logic queue_full;
  logic head_offer;
  logic head_kill;
  logic bypass;
  logic push;
  logic pop;
  logic clr_valid;
  logic [X_ID_WIDTH-1:0] clr_id;

  assign queue_empty = (count == '0);
  assign queue_full  = (count == CNT_WIDTH'(DEPTH));
  assign head        = queue_mem[rd_ptr];

  assign exe_entry = '{
    id:      exe_id_i,
    data:    exe_data_i,
    rd:      exe_rd_i,
    we:      exe_we_i,
    exc:     exe_exc_i,
    exccode: exe_exccode_i
  };

  cv32e40x_xif_commit_table #(
    .X_ID_WIDTH (X_ID_WIDTH)
  ) u_commit_table (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (commit_valid_i),
    .wr_id        (commit_id_i),
    .wr_kill      (commit_kill_i),
    .clr_valid    (clr_valid),
    .clr_id       (clr_id),
    .head_id      (head.id),
    .head_state_c (head_state),
    .exe_id       (exe_id_i),
    .exe_state_c  (exe_state)
  );

  // Head disposition: offer committed entries, drop killed ones, hold otherwise.
  // Nothing is offered while rst is high so a flush never leaks a handshake.
  assign head_offer = !rst && !queue_empty && (head_state == COMMIT_OK);
  assign head_kill  = !rst && !queue_empty && (head_state == COMMIT_KILL);

`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
  // Zero-latency path only when the core takes it this cycle; otherwise the entry queues.
  assign bypass = !rst && queue_empty && exe_valid_i && (exe_state == COMMIT_OK) && result_ready_i;
`else
  logic unused_exe_state;
  assign unused_exe_state = ^exe_state;
  assign bypass           = 1'b0;
`endif

  assign pop  = (head_offer && result_ready_i) || head_kill;
  assign push = exe_valid_i && !queue_full && !bypass;

  // A departing result (popped, discarded or bypassed) frees its commit slot.
  assign clr_valid = pop || bypass;
  assign clr_id    = bypass ? exe_id_i : head.id;

  // Result channel drive; fields are zero whenever no result is offered.
  assign out_entry        = bypass ? exe_entry : head;
  assign result_valid_o   = head_offer || bypass;
  assign result_id_o      = result_valid_o ? out_entry.id      : '0;
  assign result_data_o    = result_valid_o ? out_entry.data    : '0;
  assign result_rd_o      = result_valid_o ? out_entry.rd      : '0;
  assign result_we_o      = result_valid_o ? out_entry.we      : 1'b0;
  assign result_exc_o     = result_valid_o ? out_entry.exc     : 1'b0;
  assign result_exccode_o = result_valid_o ? out_entry.exccode : '0;

  assign exe_ready_o = !queue_full;
  assign empty_o     = queue_empty && !bypass;

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written since outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= exe_entry;
  end

  // Killing an id that is already being offered is a core protocol error.
  a_no_kill_of_offered: assert property (@(posedge clk) disable iff (rst)
    (head_offer && commit_valid_i && commit_kill_i) |-> (commit_id_i != head.id));

  // An offered result holds valid and payload until the core accepts it.
  a_result_stable: assert property (@(posedge clk) disable iff (rst)
    (result_valid_o && !result_ready_i) |=>
      (result_valid_o && $stable(result_id_o) && $stable(result_data_o) &&
       $stable(result_rd_o) && $stable(result_we_o) && $stable(result_exc_o) &&
       $stable(result_exccode_o)));

endmodule

// File: tb/tb_cv32e40x_xif_result_tx.sv
// Self-checking bench for cv32e40x_xif_result_tx: directed scenarios plus a randomized
// phase; a scoreboard queue of expected results is checked by an independent monitor.
module tb_cv32e40x_xif_result_tx;
  import cv32e40x_pkg::*;

  localparam int unsigned IDW = 4;
  localparam int unsigned RFW = 32;
  localparam int unsigned NUM_IDS = 16;
  localparam int N_ITEMS = 300;
  localparam int RAND_CYCLE_LIMIT = 20000;

  logic           clk;
  logic           rst;
  logic           exe_valid;
  logic           exe_ready;
  logic [IDW-1:0] exe_id;
  logic [RFW-1:0] exe_data;
  logic [4:0]     exe_rd;
  logic           exe_we;
  logic           exe_exc;
  logic [5:0]     exe_exccode;
  logic           commit_valid;
  logic [IDW-1:0] commit_id;
  logic           commit_kill;
  logic           result_valid;
  logic           result_ready;
  logic [IDW-1:0] result_id;
  logic [RFW-1:0] result_data;
  logic [4:0]     result_rd;
  logic           result_we;
  logic           result_exc;
  logic [5:0]     result_exccode;
  logic           empty;

  cv32e40x_xif_result_tx #(
    .DEPTH       (4),
    .X_ID_WIDTH  (IDW),
    .X_RFW_WIDTH (RFW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .exe_valid_i      (exe_valid),
    .exe_ready_o      (exe_ready),
    .exe_id_i         (exe_id),
    .exe_data_i       (exe_data),
    .exe_rd_i         (exe_rd),
    .exe_we_i         (exe_we),
    .exe_exc_i        (exe_exc),
    .exe_exccode_i    (exe_exccode),
    .commit_valid_i   (commit_valid),
    .commit_id_i      (commit_id),
    .commit_kill_i    (commit_kill),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready),
    .result_id_o      (result_id),
    .result_data_o    (result_data),
    .result_rd_o      (result_rd),
    .result_we_o      (result_we),
    .result_exc_o     (result_exc),
    .result_exccode_o (result_exccode),
    .empty_o          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  xif_result_entry_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: pops the scoreboard on every accepted result ----------------
  logic              prev_hold = 1'b0;
  xif_result_entry_t prev_entry;

  always @(negedge clk) begin
    xif_result_entry_t cur;
    xif_result_entry_t exp;
    cur.id = result_id; cur.data = result_data; cur.rd = result_rd;
    cur.we = result_we; cur.exc = result_exc; cur.exccode = result_exccode;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(result_valid), 64'(1));
        check("hold_fields", 64'(cur), 64'(prev_entry));
      end
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got id 0x%0h data 0x%0h, expected no result", result_id, result_data);
        end else begin
          exp = exp_q.pop_front();
          check("result_entry", 64'(cur), 64'(exp));
        end
      end
      prev_hold  = result_valid && !result_ready;
      prev_entry = cur;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    exe_valid    = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic drive_commit(input int id, input bit kill);
    commit_valid = 1'b1;
    commit_id    = IDW'(id);
    commit_kill  = kill;
  endtask

  task automatic drive_push(input int id, input logic [31:0] data);
    exe_valid   = 1'b1;
    exe_id      = IDW'(id);
    exe_data    = data;
    exe_rd      = 5'(id + 1);
    exe_we      = 1'(id + 1);
    exe_exc     = 1'(id);
    exe_exccode = 6'(id * 3);
  endtask

  task automatic push_exp();
    xif_result_entry_t e;
    e.id = exe_id; e.data = exe_data; e.rd = exe_rd;
    e.we = exe_we; e.exc = exe_exc; e.exccode = exe_exccode;
    exp_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct { int id; bit kill; } pend_t;

  initial begin
    pend_t pending [$];
    int    next_item;
    bit    next_kill;
    bit    pre_done;
    int    cycles;

    rst = 1'b1; exe_valid = 1'b0; exe_id = '0; exe_data = '0; exe_rd = '0;
    exe_we = 1'b0; exe_exc = 1'b0; exe_exccode = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    next_cycle();
    check("reset_exe_ready", 64'(exe_ready), 64'(1));
    check("reset_valid", 64'(result_valid), 64'(0));
    check("reset_data", 64'(result_data), 64'(0));
    check("reset_id", 64'(result_id), 64'(0));
    check("reset_empty", 64'(empty), 64'(1));

    // 1: commit before push, 1-cycle latency, pop on ready
    next_cycle(); result_ready = 1'b0; drive_commit(3, 1'b0);
    next_cycle(); drive_push(3, 32'hDEADBEEF); push_exp();
    #1 check("t1_valid_c1", 64'(result_valid), 64'(0));
    next_cycle(); result_ready = 1'b1;
    #1 check("t1_valid_c2", 64'(result_valid), 64'(1));
    check("t1_data_c2", 64'(result_data), 64'(32'hDEADBEEF));
    next_cycle();
    #1 check("t1_empty_c3", 64'(empty), 64'(1));
    check("t1_valid_c3", 64'(result_valid), 64'(0));

    // 2: uncommitted results wait; out-of-order commits still deliver in issue order
    next_cycle(); drive_push(1, 32'h1111_0001); push_exp();
    next_cycle(); drive_push(2, 32'h2222_0002); push_exp();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1 check("t2_no_valid", 64'(result_valid), 64'(0));
    end
    next_cycle(); drive_commit(2, 1'b0);
    #1 check("t2_no_valid_c2", 64'(result_valid), 64'(0));
    next_cycle(); drive_commit(1, 1'b0);
    #1 check("t2_no_valid_c1", 64'(result_valid), 64'(0));
    next_cycle();
    #1 check("t2_first_valid", 64'(result_valid), 64'(1));
    check("t2_first_id", 64'(result_id), 64'(1));
    next_cycle();
    #1 check("t2_second_valid", 64'(result_valid), 64'(1));
    check("t2_second_id", 64'(result_id), 64'(2));
    next_cycle();
    #1 check("t2_empty", 64'(empty), 64'(1));

    // 3: killed head discarded silently, next committed result follows
    next_cycle(); drive_push(4, 32'h4444_4444);
    next_cycle(); drive_push(5, 32'h5555_5555); push_exp();
    next_cycle(); drive_commit(4, 1'b1);
    #1 check("t3_valid_before_kill", 64'(result_valid), 64'(0));
    next_cycle(); drive_commit(5, 1'b0);
    #1 check("t3_valid_on_discard", 64'(result_valid), 64'(0));
    next_cycle();
    #1 check("t3_valid_id5", 64'(result_valid), 64'(1));
    check("t3_id5", 64'(result_id), 64'(5));
    next_cycle();
    #1 check("t3_empty", 64'(empty), 64'(1));

    // 4: fill with ready low, hold, then drain back-to-back
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive_commit(i, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive_push(i, $urandom); push_exp();
    end
    next_cycle();
    #1 check("t4_full_not_ready", 64'(exe_ready), 64'(0));
    check("t4_full_valid", 64'(result_valid), 64'(1));
    repeat (10) next_cycle();
    result_ready = 1'b1;
    #1 check("t4_drain0_id", 64'(result_id), 64'(0));
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      #1 check("t4_drain_valid", 64'(result_valid), 64'(1));
      check("t4_drain_id", 64'(result_id), 64'(i));
      check("t4_exe_ready", 64'(exe_ready), 64'(1));
    end
    next_cycle();
    #1 check("t4_empty", 64'(empty), 64'(1));

    // 5: simultaneous push and pop at count 2, then mid-stream reset
    result_ready = 1'b0;
    next_cycle(); drive_commit(5, 1'b0);
    next_cycle(); drive_commit(8, 1'b0);
    next_cycle(); drive_commit(6, 1'b0);
    next_cycle(); drive_push(5, 32'h0505_0505); push_exp();
    next_cycle(); drive_push(8, 32'h0808_0808); push_exp();
    next_cycle(); drive_push(6, 32'h0606_0606); push_exp(); result_ready = 1'b1;
    #1 check("t5_pop_id5", 64'(result_id), 64'(5));
    check("t5_push_accepted", 64'(exe_ready), 64'(1));
    next_cycle(); result_ready = 1'b0;
    #1 check("t5_next_id8", 64'(result_id), 64'(8));
    next_cycle(); rst = 1'b1; exp_q.delete();
    #1 check("t5_valid_in_rst", 64'(result_valid), 64'(0));
    next_cycle(); rst = 1'b0;
    #1 check("t5_post_rst_valid", 64'(result_valid), 64'(0));
    check("t5_post_rst_ready", 64'(exe_ready), 64'(1));
    check("t5_post_rst_empty", 64'(empty), 64'(1));

    // 6: committed id offered into an empty queue with the core ready
    result_ready = 1'b1;
    next_cycle(); drive_commit(7, 1'b0);
    next_cycle(); drive_push(7, 32'hCAFEF00D); push_exp();
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
    #1 check("t6_bypass_valid", 64'(result_valid), 64'(1));
    check("t6_bypass_data", 64'(result_data), 64'(32'hCAFEF00D));
    next_cycle();
    #1 check("t6_bypass_valid_after", 64'(result_valid), 64'(0));
    check("t6_bypass_empty", 64'(empty), 64'(1));
`else
    #1 check("t6_valid_same_cycle", 64'(result_valid), 64'(0));
    next_cycle();
    #1 check("t6_valid_next", 64'(result_valid), 64'(1));
    check("t6_data_next", 64'(result_data), 64'(32'hCAFEF00D));
    next_cycle();
    #1 check("t6_empty", 64'(empty), 64'(1));
`endif

    // randomized traffic: ids rotate through all slots, commits/kills arrive in random order
    next_item = 0;
    next_kill = ($urandom_range(0, 3) == 0);
    pre_done  = 1'b0;
    cycles    = 0;
    while ((next_item < N_ITEMS || pending.size() > 0) && cycles < RAND_CYCLE_LIMIT) begin
      next_cycle();
      cycles++;
      result_ready = ($urandom_range(0, 3) != 0);
      if (next_item < N_ITEMS && !pre_done && $urandom_range(0, 7) == 0) begin
        drive_commit(next_item % NUM_IDS, next_kill);
        pre_done = 1'b1;
      end else if (pending.size() > 0 && $urandom_range(0, 1) == 0) begin
        int k;
        k = $urandom_range(0, pending.size() - 1);
        drive_commit(pending[k].id, pending[k].kill);
        pending.delete(k);
      end
      if (next_item < N_ITEMS && $urandom_range(0, 3) != 0) begin
        drive_push(next_item % NUM_IDS, $urandom);
        if (exe_ready) begin
          if (!next_kill) push_exp();
          if (!pre_done) pending.push_back('{next_item % NUM_IDS, next_kill});
          next_item++;
          next_kill = ($urandom_range(0, 3) == 0);
          pre_done  = 1'b0;
        end
      end
    end
    if (cycles >= RAND_CYCLE_LIMIT) begin
      tests++;
      fails++;
      $display("FAIL random_phase_timeout: got %0d items issued, expected %0d", next_item, N_ITEMS);
    end

    // drain
    next_cycle();
    result_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      next_cycle();
      cycles++;
    end
    repeat (6) next_cycle();
    check("drain_left", 64'(exp_q.size()), 64'(0));
    check("drain_empty", 64'(empty), 64'(1));
    check("drain_exe_ready", 64'(exe_ready), 64'(1));
    check("drain_valid", 64'(result_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
